// File: rtl/reg_access_pkg.sv
// reg_access_pkg: FSM state encoding and default geometry for the register-bank access sequencer
// Ports: none
package reg_access_pkg;
  localparam int DEF_BUS_WIDTH = 15;
  localparam int DEF_NUM_REGS = DEF_BUS_WIDTH * 2 + 1;
  localparam int DEF_ADDR_W = 5;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_SETUP = 3'd1;
  localparam state_t S_STROBE = 3'd2;
  localparam state_t S_HOLD = 3'd3;
  localparam state_t S_SAMPLE = 3'd4;
  localparam state_t S_RESP = 3'd5;
endpackage

// File: rtl/reg_access_ctrl_if.sv
// reg_access_ctrl_if: host request/response channel plus register-bank strobe/select/data bus
// Ports: master = host and bank side, slave = sequencer side
interface reg_access_ctrl_if
  import reg_access_pkg::*;
#(
  parameter int bus_width = DEF_BUS_WIDTH,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W = DEF_ADDR_W
) ();
  logic req_valid;
  logic req_ready;
  logic req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [bus_width:0] req_wdata;
  logic rsp_valid;
  logic rsp_ready;
  logic [bus_width:0] rsp_rdata;
  logic rsp_err;
  logic wrb;
  logic [NUM_REGS-1:0] reg_sel;
  logic [bus_width:0] din;
  logic [bus_width:0] rdout;
  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready, rdout,
    input req_ready, rsp_valid, rsp_rdata, rsp_err, wrb, reg_sel, din
  );
  modport slave (
    input req_valid, req_write, req_addr, req_wdata, rsp_ready, rdout,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, wrb, reg_sel, din
  );
endinterface

// File: rtl/reg_sel_dec.sv
// reg_sel_dec: binary-to-one-hot register select decoder with enable and out-of-range flag
// Ports: addr/en in, sel one-hot out (zero when disabled or out of range), oor out
module reg_sel_dec #(
  parameter int NUM_REGS = 31,
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0]   addr,
  input  logic                en,
  output logic [NUM_REGS-1:0] sel,
  output logic                oor
);
  assign oor = 32'(addr) >= NUM_REGS;
  assign sel = (en && !oor) ? {{(NUM_REGS-1){1'b0}}, 1'b1} << addr : '0;
endmodule

// File: rtl/reg_access_ctrl.sv
// reg_access_ctrl: sequences one host request into select/data/write-strobe timing with write readback verify
// Ports: sysclk, reset (sync, active high), bus = slave side of reg_access_ctrl_if
module reg_access_ctrl
  import reg_access_pkg::*;
#(
  parameter int bus_width = DEF_BUS_WIDTH,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input logic sysclk,
  input logic reset,
  reg_access_ctrl_if.slave bus
);
  state_t state;
  logic wr;
  logic [ADDR_W-1:0] addr;
  logic [bus_width:0] wdata;
  logic accept;
  logic dec_en;
  logic oor;
  logic [ADDR_W-1:0] dec_addr;
  logic [NUM_REGS-1:0] dec_sel;
  assign accept = state == S_IDLE && bus.req_ready && bus.req_valid;
  // decode the select for the next cycle so reg_sel itself is a register
  assign dec_addr = state == S_IDLE ? bus.req_addr : addr;
  assign dec_en = state == S_IDLE ? accept : (state == S_SETUP || state == S_STROBE || state == S_HOLD);
  reg_sel_dec #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) u_dec (
    .addr(dec_addr),
    .en(dec_en),
    .sel(dec_sel),
    .oor(oor)
  );
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state <= S_IDLE;
      wr <= 1'b0;
      addr <= '0;
      wdata <= '0;
      bus.req_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err <= 1'b0;
      bus.wrb <= 1'b1;
      bus.reg_sel <= '0;
      bus.din <= '0;
    end else begin
      bus.reg_sel <= dec_sel;
      bus.wrb <= !(state == S_SETUP && wr);
      case (state)
        S_IDLE:
          if (accept) begin
            wr <= bus.req_write;
            addr <= bus.req_addr;
            wdata <= bus.req_wdata;
            bus.req_ready <= 1'b0;
            if (oor) begin
              state <= S_RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_rdata <= '0;
              bus.rsp_err <= 1'b1;
            end else begin
              state <= S_SETUP;
              bus.din <= bus.req_write ? bus.req_wdata : '0;
            end
          end else begin
            bus.req_ready <= 1'b1;
          end
        S_SETUP: state <= wr ? S_STROBE : S_SAMPLE;
        S_STROBE: state <= S_HOLD;
        S_HOLD: state <= S_SAMPLE;
        S_SAMPLE: begin
          state <= S_RESP;
          bus.rsp_valid <= 1'b1;
          bus.rsp_rdata <= bus.rdout;
          bus.rsp_err <= wr && (bus.rdout != wdata);
          bus.din <= '0;
        end
        S_RESP:
          if (bus.rsp_ready) begin
            state <= S_IDLE;
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
          end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_reg_access_ctrl.sv
// tb_reg_access_ctrl: directed scoreboard bench for reg_access_ctrl against a simple register bank model
module tb_reg_access_ctrl;
  typedef struct packed {
    logic [15:0] d;
    logic        e;
  } exp_t;
  localparam logic [15:0] STUCK3 = 16'h0001;
  logic sysclk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  exp_t q[$];
  exp_t e;
  logic [15:0] mem [31];
  reg_access_ctrl_if bus ();
  reg_access_ctrl dut (.sysclk(sysclk), .reset(reset), .bus(bus));
  always #5 sysclk = ~sysclk;
  // bank: cells latch din while wrb is low; register 3 has bit 0 stuck at 0
  always @(posedge sysclk)
    if (!bus.wrb)
      for (int i = 0; i < 31; i++)
        if (bus.reg_sel[i]) mem[i] <= bus.din & ~((i == 3) ? STUCK3 : 16'h0000);
  always_comb begin
    bus.rdout = '0;
    for (int j = 0; j < 31; j++)
      if (bus.reg_sel[j]) bus.rdout = bus.rdout | mem[j];
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  always @(negedge sysclk)
    if (bus.rsp_valid && bus.rsp_ready) begin
      chk("rsp_expected", 32'(q.size() != 0), 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(e.d));
        chk("rsp_err", 32'(bus.rsp_err), 32'(e.e));
      end
    end
  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask
  task automatic send(input logic w, input logic [4:0] a, input logic [15:0] d);
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr = a;
    bus.req_wdata = d;
    while (!bus.req_ready && n < 20) begin
      tick();
      n++;
    end
    if (!bus.req_ready) chk("req_ready_timeout", 32'(bus.req_ready), 1);
    tick();
    bus.req_valid = 1'b0;
  endtask
  task automatic wait_rsp(input int lat, input string tag);
    for (int c = 1; c < lat; c++) begin
      chk({tag, "_early_valid"}, 32'(bus.rsp_valid), 0);
      tick();
    end
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 1);
  endtask
  initial begin
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr = 5'd1;
    bus.req_wdata = 16'h0;
    bus.rsp_ready = 1'b1;
    tick();
    tick();
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_wrb", 32'(bus.wrb), 1);
    chk("rst_reg_sel", 32'(bus.reg_sel), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 0);
    chk("rst_din", 32'(bus.din), 0);
    reset = 1'b0;
    tick();
    chk("rel_req_ready", 32'(bus.req_ready), 1);
    bus.req_valid = 1'b0;
    tick();
    q.push_back('{d: 16'hA5C3, e: 1'b0});
    send(1'b1, 5'd1, 16'hA5C3);
    for (int c = 1; c <= 4; c++) begin
      chk("wr1_reg_sel", 32'(bus.reg_sel), 32'h2);
      chk("wr1_din", 32'(bus.din), 32'hA5C3);
      chk("wr1_wrb", 32'(bus.wrb), (c == 2) ? 0 : 1);
      chk("wr1_no_valid", 32'(bus.rsp_valid), 0);
      tick();
    end
    chk("wr1_rsp_valid", 32'(bus.rsp_valid), 1);
    chk("wr1_req_ready_busy", 32'(bus.req_ready), 0);
    tick();
    chk("wr1_rsp_done", 32'(bus.rsp_valid), 0);
    chk("wr1_req_ready_back", 32'(bus.req_ready), 1);
    chk("wr1_sel_idle", 32'(bus.reg_sel), 0);
    q.push_back('{d: 16'hFFFE, e: 1'b1});
    send(1'b1, 5'd3, 16'hFFFF);
    wait_rsp(5, "wr3");
    tick();
    q.push_back('{d: 16'h1234, e: 1'b0});
    send(1'b1, 5'd30, 16'h1234);
    wait_rsp(5, "wr30");
    tick();
    q.push_back('{d: 16'h1234, e: 1'b0});
    send(1'b0, 5'd30, 16'hBEEF);
    for (int c = 1; c <= 2; c++) begin
      chk("rd30_wrb", 32'(bus.wrb), 1);
      chk("rd30_reg_sel", 32'(bus.reg_sel), 32'h4000_0000);
      chk("rd30_din", 32'(bus.din), 0);
      chk("rd30_no_valid", 32'(bus.rsp_valid), 0);
      tick();
    end
    chk("rd30_rsp_valid", 32'(bus.rsp_valid), 1);
    chk("rd30_rsp_sel", 32'(bus.reg_sel), 0);
    tick();
    q.push_back('{d: 16'h0000, e: 1'b1});
    send(1'b1, 5'd31, 16'h7777);
    chk("oor_rsp_valid", 32'(bus.rsp_valid), 1);
    chk("oor_reg_sel", 32'(bus.reg_sel), 0);
    chk("oor_wrb", 32'(bus.wrb), 1);
    chk("oor_din", 32'(bus.din), 0);
    tick();
    bus.rsp_ready = 1'b0;
    q.push_back('{d: 16'h5A5A, e: 1'b0});
    send(1'b1, 5'd5, 16'h5A5A);
    wait_rsp(5, "wr5");
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr = 5'd2;
    bus.req_wdata = 16'h1111;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("stall_rsp_valid", 32'(bus.rsp_valid), 1);
      chk("stall_rsp_rdata", 32'(bus.rsp_rdata), 32'h5A5A);
      chk("stall_rsp_err", 32'(bus.rsp_err), 0);
      chk("stall_req_ready", 32'(bus.req_ready), 0);
    end
    bus.rsp_ready = 1'b1;
    tick();
    chk("stall_released", 32'(bus.rsp_valid), 0);
    send(1'b1, 5'd2, 16'h1111);
    chk("wr2_setup_sel", 32'(bus.reg_sel), 32'h4);
    tick();
    chk("wr2_strobe_wrb", 32'(bus.wrb), 0);
    reset = 1'b1;
    tick();
    chk("rst_strobe_wrb", 32'(bus.wrb), 1);
    chk("rst_strobe_reg_sel", 32'(bus.reg_sel), 0);
    chk("rst_strobe_rsp_valid", 32'(bus.rsp_valid), 0);
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("dropped_rsp_valid", 32'(bus.rsp_valid), 0);
    end
    chk("scoreboard_empty", 32'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
